// File: rtl/mul_div_unit_if.sv
// Port bundle between the pipeline controller and mul_div_unit.
// start is sampled only while busy is low; done pulses for one cycle with HI/LO already updated.
interface mul_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  state_dbg;

    modport master (
        output start, op, rs_val, rt_val, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo, state_dbg
    );

    modport slave (
        input  start, op, rs_val, rt_val, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo, state_dbg
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Define MDU_FAST_ZERO_EN to finish zero-operand operations in a single cycle.
module mul_div_unit (
    input  logic          clk,
    input  logic          rst,
    mul_div_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        is_div;
    logic        neg_q;
    logic        neg_r;
    logic        dz;
    logic [31:0] mcand;
    logic [31:0] raw_rs;
    logic [63:0] acc;
    logic [31:0] rem;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        busy_r;
    logic        done_r;
    logic        dz_r;

    logic        rs_neg;
    logic        rt_neg;
    logic [31:0] rs_abs;
    logic [31:0] rt_abs;
    logic        rt_zero;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        ge;
    logic [31:0] div_sub;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // op[0] = 0 marks the signed variants (MULT, DIV).
    always_comb begin
        rs_neg  = ~bus.op[0] & bus.rs_val[31];
        rt_neg  = ~bus.op[0] & bus.rt_val[31];
        rs_abs  = rs_neg ? (~bus.rs_val + 32'd1) : bus.rs_val;
        rt_abs  = rt_neg ? (~bus.rt_val + 32'd1) : bus.rt_val;
        rt_zero = (bus.rt_val == 32'd0);
    end

`ifdef MDU_FAST_ZERO_EN
    logic fast_zero;
    always_comb begin
        fast_zero = rt_zero | (~bus.op[1] & (bus.rs_val == 32'd0));
    end
`endif

    // Multiply keeps the multiplier in acc[31:0] and shifts the product in from the top.
    // Divide keeps the dividend/quotient in acc[31:0]; remainder stays below the divisor.
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
        div_shift = {rem, acc[31]};
        ge        = (div_shift >= {1'b0, mcand});
        div_sub   = div_shift[31:0] - mcand;
        prod_fix  = neg_q ? (~acc + 64'd1) : acc;
        quo_fix   = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_fix   = neg_r ? (~rem + 32'd1) : rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            mcand  <= 32'd0;
            raw_rs <= 32'd0;
            acc    <= 64'd0;
            rem    <= 32'd0;
            hi_r   <= 32'd0;
            lo_r   <= 32'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.hi_we) hi_r <= bus.wdata;
                    if (bus.lo_we) lo_r <= bus.wdata;
                    if (bus.start) begin
                        is_div <= bus.op[1];
                        raw_rs <= bus.rs_val;
                        cnt    <= 5'd0;
                        rem    <= 32'd0;
                        busy_r <= 1'b1;
                        neg_r  <= rs_neg;
                        neg_q  <= rs_neg ^ rt_neg;
                        dz     <= bus.op[1] & rt_zero;
                        if (bus.op[1]) begin
                            mcand <= rt_abs;
                            acc   <= {32'd0, rs_abs};
                        end else begin
                            mcand <= rs_abs;
                            acc   <= {32'd0, rt_abs};
                        end
`ifdef MDU_FAST_ZERO_EN
                        if (fast_zero) begin
                            state <= FINISH;
                            if (!bus.op[1]) acc <= 64'd0;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (is_div) begin
                        rem <= ge ? div_sub : div_shift[31:0];
                        acc <= {32'd0, acc[30:0], ge};
                    end else begin
                        acc <= {mul_sum, acc[31:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FINISH;
                end
                FINISH: begin
                    // Divide by zero reports the raw dividend, never sign-corrected.
                    if (dz) begin
                        hi_r <= raw_rs;
                        lo_r <= 32'hFFFF_FFFF;
                    end else if (is_div) begin
                        hi_r <= rem_fix;
                        lo_r <= quo_fix;
                    end else begin
                        hi_r <= prod_fix[63:32];
                        lo_r <= prod_fix[31:0];
                    end
                    done_r <= 1'b1;
                    dz_r   <= dz;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dz_r;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
    assign bus.state_dbg   = state;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, corner sequences, random ops vs model.
module tb_mul_div_unit;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  mul_div_unit_if m();
  mul_div_unit dut (.clk(clk), .rst(rst), .bus(m));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; returns {dz, hi, lo}.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'b00: begin p = sa * sb; return {1'b0, p}; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
      2'b10: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb; r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  function automatic int exp_latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_FAST_ZERO_EN
    if (o[1] ? (b == 0) : (a == 0 || b == 0)) return 1;
`endif
    return 33;
  endfunction

  // Drives start at a falling edge; returns #1 after the accepting edge E0.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    m.start = 1'b1; m.op = o; m.rs_val = a; m.rt_val = b;
    @(posedge clk); #1;
    m.start = 1'b0;
    m.rs_val = $urandom; m.rt_val = $urandom;
  endtask

  task automatic wait_done(output int lat, output int busy_cyc);
    lat = 0; busy_cyc = 0;
    while (!m.done && lat < 100) begin
      if (m.busy) busy_cyc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input logic edz);
    int lat, bc, el_lat;
    el_lat = exp_latency(o, a, b);
    issue(o, a, b);
    check({tag, " done_low_after_start"}, m.done, 0);
    check({tag, " busy_after_start"}, m.busy, 1);
    wait_done(lat, bc);
    check({tag, " latency"}, lat, el_lat);
    check({tag, " busy_cycles"}, bc, el_lat);
    check({tag, " hi"}, m.hi, eh);
    check({tag, " lo"}, m.lo, el);
    check({tag, " div_by_zero"}, m.div_by_zero, edz);
  endtask

  initial begin
    int lat, bc;
    logic        seen;
    logic [64:0] r;
    logic [1:0]  o;
    logic [31:0] a, b;
    n_checks = 0; n_errors = 0;
    rst = 1'b1;
    m.start = 0; m.op = 0; m.rs_val = 0; m.rt_val = 0; m.hi_we = 0; m.lo_we = 0; m.wdata = 0;

    vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[4] = '{2'b11, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{2'b11, 32'd100,       32'd7,        32'd2,         32'd14,         1'b0};
    vecs[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[7] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[8] = '{2'b10, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", m.busy, 0);
    check("reset done", m.done, 0);
    check("reset dz", m.div_by_zero, 0);
    check("reset hi", m.hi, 0);
    check("reset lo", m.lo, 0);
    @(negedge clk); rst = 1'b0;

    // Back-to-back table run: each start lands in the previous done cycle.
    for (int i = 0; i < 9; i++) begin
      r = model(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d model_agrees", i), r, {vecs[i].exp_dz, vecs[i].exp_hi, vecs[i].exp_lo});
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dz);
    end
    @(posedge clk); #1;
    check("done one cycle", m.done, 0);

    // MTHI/MTLO in IDLE.
    @(negedge clk); m.hi_we = 1; m.lo_we = 1; m.wdata = 32'h1111_2222;
    @(posedge clk); #1; m.hi_we = 0; m.lo_we = 0;
    check("mt both hi", m.hi, 32'h1111_2222);
    check("mt both lo", m.lo, 32'h1111_2222);
    @(negedge clk); m.lo_we = 1; m.wdata = 32'h0000_005A;
    @(posedge clk); #1; m.lo_we = 0;
    check("mtlo lo", m.lo, 32'h0000_005A);
    check("mtlo hi kept", m.hi, 32'h1111_2222);

    // MTHI and start while busy are both ignored.
    issue(2'b01, 32'd3, 32'd5);
    @(negedge clk);
    m.hi_we = 1; m.wdata = 32'hAAAA_5555; m.start = 1; m.op = 2'b11; m.rs_val = 32'd99; m.rt_val = 32'd1;
    @(posedge clk); #1;
    m.hi_we = 0; m.start = 0;
    @(posedge clk); #1;
    check("mthi busy ignored", m.hi, 32'h1111_2222);
    wait_done(lat, bc);
    check("busy start latency", lat, 31);
    check("busy start hi", m.hi, 32'd0);
    check("busy start lo", m.lo, 32'd15);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (m.done || m.busy) seen = 1;
    end
    check("no queued op", seen, 0);

    // start and MTLO in the same cycle: write lands, then result overwrites.
    @(negedge clk);
    m.start = 1; m.op = 2'b00; m.rs_val = 32'hFFFF_FFFE; m.rt_val = 32'd3; m.lo_we = 1; m.wdata = 32'h77;
    @(posedge clk); #1;
    m.start = 0; m.lo_we = 0;
    check("start+mtlo lo", m.lo, 32'h77);
    wait_done(lat, bc);
    check("start+mtlo result hi", m.hi, 32'hFFFF_FFFF);
    check("start+mtlo result lo", m.lo, 32'hFFFF_FFFA);

    // Reset mid-CALC aborts the operation.
    @(negedge clk); m.hi_we = 1; m.lo_we = 1; m.wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1; m.hi_we = 0; m.lo_we = 0;
    issue(2'b01, 32'h10, 32'h20);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort busy", m.busy, 0);
    check("abort hi", m.hi, 0);
    check("abort lo", m.lo, 0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (m.done) seen = 1;
    end
    check("abort no done", seen, 0);

    // Random operations against the model.
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'hFF;
      r = model(o, a, b);
      do_op($sformatf("rnd%0d", i), o, a, b, r[63:32], r[31:0], r[64]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
